// File: rtl/nios_mul_pkg.sv
// Shared definitions for the sequential NIOS multiplier: FSM state encoding
// and the op_mode constants selecting the low or unsigned-high product word.
package nios_mul_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE1 = 3'd1,
      CAP1   = 3'd2,
      CAP2   = 3'd3,
      SUM    = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam logic MODE_LO = 1'b0;
   localparam logic MODE_HI = 1'b1;

endpackage

// File: rtl/nios_mul_combine.sv
// SUM-stage combiner: folds the 16x16 partial products into a 64-bit product
// and selects the low (MUL) or high (MULXUU) 32-bit word.
module nios_mul_combine
   import nios_mul_pkg::*;
(
   input  logic [31:0] p1,
   input  logic [31:0] p2,
   input  logic [31:0] p3,
   input  logic [31:0] p4,
   input  logic        mode,
   output logic [31:0] word
);

   logic [32:0] mid;
   logic [63:0] hi_part;
   logic [63:0] s;

   always_comb begin
      // mid keeps the carry out of p2+p3 so it lands at bit 48 of s
      mid     = {1'b0, p2} + {1'b0, p3};
      hi_part = (mode == MODE_HI) ? {p4, 32'h0} : '0;
      s       = {32'h0, p1} + {15'h0, mid, 16'h0} + hi_part;
      word    = (mode == MODE_HI) ? s[63:32] : s[31:0];
   end

endmodule

// File: rtl/nios_mul_seq.sv
// Sequential 32x32 multiplier driving an external registered 16x16 partial-
// product cell; one pass for the low word, a second cell pass for the high word.
module nios_mul_seq
   import nios_mul_pkg::*;
#(
   parameter int unsigned CELL_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic        op_mode,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [31:0] cell_src1,
   output logic [31:0] cell_src2,
   output logic        cell_en,
   input  logic [31:0] cell_p1,
   input  logic [31:0] cell_p2,
   input  logic [31:0] cell_p3,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   // The capture schedule assumes products one cycle after cell_en.
   if (CELL_LAT != 1) begin : g_unsupported_cell_lat
   end

   state_t      state;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic        mode_q;
   logic [31:0] p1_q;
   logic [31:0] p2_q;
   logic [31:0] p3_q;
   logic [31:0] p4_q;
   logic [31:0] sum_word;

   nios_mul_combine u_combine (
      .p1   (p1_q),
      .p2   (p2_q),
      .p3   (p3_q),
      .p4   (p4_q),
      .mode (mode_q),
      .word (sum_word)
   );

   // Cell drive, busy and done are registered for the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         mode_q    <= MODE_LO;
         p1_q      <= '0;
         p2_q      <= '0;
         p3_q      <= '0;
         p4_q      <= '0;
         result    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cell_en   <= 1'b0;
         cell_src1 <= '0;
         cell_src2 <= '0;
      end else begin
         done      <= 1'b0;
         cell_en   <= 1'b0;
         cell_src1 <= '0;
         cell_src2 <= '0;
         if (state != IDLE && abort) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     a_q       <= op_a;
                     b_q       <= op_b;
                     mode_q    <= op_mode;
                     p4_q      <= '0;
                     state     <= ISSUE1;
                     busy      <= 1'b1;
                     cell_en   <= 1'b1;
                     cell_src1 <= op_a;
                     cell_src2 <= op_b;
                  end
               end
               ISSUE1: begin
                  state <= CAP1;
                  if (mode_q == MODE_HI) begin
                     cell_en   <= 1'b1;
                     cell_src1 <= {16'h0, a_q[31:16]};
                     cell_src2 <= {16'h0, b_q[31:16]};
                  end
               end
               CAP1: begin
                  p1_q  <= cell_p1;
                  p2_q  <= cell_p2;
                  p3_q  <= cell_p3;
                  state <= (mode_q == MODE_HI) ? CAP2 : SUM;
               end
               CAP2: begin
                  p4_q  <= cell_p1;
                  state <= SUM;
               end
               SUM: begin
                  result <= sum_word;
                  done   <= 1'b1;
                  state  <= DONE;
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
